// File: rtl/glb_instruction_sequencer_pkg.sv
// glb_instruction_sequencer_pkg: shared types and helpers for the global-buffer sequencer.
//   global_buffer_instruction_t : 4-bit opcode set
//   glb_state_t                 : sequencer FSM states
//   glb_region_t                : {start, len} region descriptor (len 0 = whole SRAM)
//   glb_advance                 : wrap-aware pointer step, returns {wrapped, next}
package glb_instruction_sequencer_pkg;
    localparam int GLB_MEM_DEPTH = 1024;
    localparam int GLB_ADDR_W = $clog2(GLB_MEM_DEPTH);
    typedef enum logic [3:0] {
        I_NOP             = 4'd0,
        I_POINTER_RESET   = 4'd1,
        I_LOAD_WEIGHT     = 4'd2,
        I_LOAD_ACTIVATION = 4'd3,
        I_LOAD_OUTPUT     = 4'd4,
        I_READ_ACTIVATION = 4'd5
    } global_buffer_instruction_t;
    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} glb_state_t;
    typedef struct packed {
        logic [GLB_ADDR_W-1:0] start;
        logic [GLB_ADDR_W-1:0] len;
    } glb_region_t;
    // start+len-1 wraps naturally in addrWidth bits, so len 0 makes the last slot start-1,
    // i.e. the region covers the full SRAM.
    function automatic logic [GLB_ADDR_W:0] glb_advance(input logic [GLB_ADDR_W-1:0] ptr, input glb_region_t r);
        logic [GLB_ADDR_W-1:0] last;
        last = r.start + r.len - GLB_ADDR_W'(1);
        return (ptr == last) ? {1'b1, r.start} : {1'b0, ptr + GLB_ADDR_W'(1)};
    endfunction
endpackage

// File: rtl/glb_sram_1rw.sv
// glb_sram_1rw: single-port synchronous SRAM, width x depth, 1-cycle registered read.
//   clk   : clock
//   we    : write mem[addr] <= wdata
//   re    : read, q <= mem[addr] on the next edge
//   addr  : shared address
//   wdata : write data
//   q     : read data (holds until the next read)
module glb_sram_1rw #(
    parameter int width = 128,
    parameter int depth = 1024,
    localparam int aw = $clog2(depth)
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [aw-1:0]    addr,
    input  logic [width-1:0] wdata,
    output logic [width-1:0] q
);
    logic [width-1:0] mem [depth];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) q <= mem[addr];
    end
endmodule

// File: rtl/glb_instruction_sequencer.sv
// glb_instruction_sequencer: executes global-buffer instructions against a single-port SRAM
// split into weight/activation/output regions with auto-incrementing, wrapping pointers.
//   instr_*      : instruction channel (valid/ready), opcode + burst length
//   *_start_addr/*_len : region configuration, sampled only on I_POINTER_RESET
//   wr_*         : write beat channel into the selected region
//   rd_*         : activation read beat channel out of the 2-entry read FIFO
//   busy/done    : FSM not idle / one-cycle completion pulse
//   wrap_flag/illegal_flag : sticky status
module glb_instruction_sequencer
    import glb_instruction_sequencer_pkg::*;
#(
    parameter int dataSize = 8,
    parameter int interfaceDepth = 16,
    parameter int memDepth = GLB_MEM_DEPTH,
    parameter int lenWidth = 16,
    localparam int W = dataSize * interfaceDepth,
    localparam int addrWidth = $clog2(memDepth)
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [3:0]           instr,
    input  logic [lenWidth-1:0]  instr_len,
    input  logic [addrWidth-1:0] weight_start_addr,
    input  logic [addrWidth-1:0] weight_len,
    input  logic [addrWidth-1:0] act_start_addr,
    input  logic [addrWidth-1:0] act_len,
    input  logic [addrWidth-1:0] out_start_addr,
    input  logic [addrWidth-1:0] out_len,
    input  logic [W-1:0]         wr_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    output logic [W-1:0]         rd_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 wrap_flag,
    output logic                 illegal_flag
);
    glb_state_t state, state_n;
    logic done_n;
    glb_region_t w_reg, a_reg, o_reg, cur_reg;
    // pointer slots: 0 weight, 1 activation write, 2 output, 3 activation read
    logic [addrWidth-1:0] ptr [4];
    logic [1:0] sel, cur;
    logic [lenWidth-1:0] beats;
    logic [W-1:0] fifo [2];
    logic [1:0] fcnt, fidx;
    logic [W-1:0] q;
    logic inflight, accept, wr_hs, pop, pop_f, push, issue, step, last, adv_wrap;
    logic is_load, is_read;
    logic [addrWidth-1:0] adv_ptr;

    assign accept = instr_valid && state == IDLE;
    assign is_load = instr inside {I_LOAD_WEIGHT, I_LOAD_ACTIVATION, I_LOAD_OUTPUT};
    assign is_read = instr == I_READ_ACTIVATION;
    assign wr_hs = state == WRITE && wr_valid;
    // The FIFO head comes first; when it is empty the SRAM output is forwarded directly.
    assign rd_valid = fcnt != 2'd0 || inflight;
    assign rd_data = fcnt != 2'd0 ? fifo[0] : inflight ? q : '0;
    assign pop = rd_valid && rd_ready;
    assign pop_f = pop && fcnt != 2'd0;
    assign push = inflight && !(pop && fcnt == 2'd0);
    assign fidx = fcnt - {1'b0, pop_f};
    // Only issue when the returning beat is guaranteed a FIFO slot.
    assign issue = state == READ && ({1'b0, fcnt} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
    assign step = wr_hs || issue;
    assign last = beats == lenWidth'(1);
    assign cur = state == WRITE ? sel : 2'd3;
    assign cur_reg = cur == 2'd0 ? w_reg : cur == 2'd2 ? o_reg : a_reg;
    assign {adv_wrap, adv_ptr} = glb_advance(ptr[cur], cur_reg);
    assign instr_ready = state == IDLE;
    assign wr_ready = state == WRITE;
    assign busy = state != IDLE;

    glb_sram_1rw #(.width(W), .depth(memDepth)) u_sram (
        .clk(clk), .we(wr_hs), .re(issue), .addr(ptr[cur]), .wdata(wr_data), .q(q)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            done <= 1'b0;
        end else begin
            state <= state_n;
            done <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        done_n = 1'b0;
        unique case (state)
            IDLE: if (accept) begin
                if (is_load && instr_len != '0) state_n = WRITE;
                else if (is_read && instr_len != '0) state_n = READ;
                else done_n = 1'b1;
            end
            WRITE: if (wr_hs && last) begin
                state_n = IDLE;
                done_n = 1'b1;
            end
            READ: if (issue && last) state_n = DRAIN;
            DRAIN: if (pop && ({1'b0, fcnt} + {2'b0, inflight}) == 3'd1) begin
                state_n = IDLE;
                done_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 4; i++) ptr[i] <= '0;
            fifo[0] <= '0;
            fifo[1] <= '0;
            w_reg <= '0;
            a_reg <= '0;
            o_reg <= '0;
            sel <= 2'd0;
            beats <= '0;
            fcnt <= 2'd0;
            inflight <= 1'b0;
            wrap_flag <= 1'b0;
            illegal_flag <= 1'b0;
        end else begin
            if (accept) begin
                beats <= instr_len;
                sel <= instr == I_LOAD_WEIGHT ? 2'd0 : instr == I_LOAD_OUTPUT ? 2'd2 : 2'd1;
                if (instr > 4'd5) illegal_flag <= 1'b1;
                if (instr == I_POINTER_RESET) begin
                    w_reg <= '{start: weight_start_addr, len: weight_len};
                    a_reg <= '{start: act_start_addr, len: act_len};
                    o_reg <= '{start: out_start_addr, len: out_len};
                    ptr[0] <= weight_start_addr;
                    ptr[1] <= act_start_addr;
                    ptr[2] <= out_start_addr;
                    ptr[3] <= act_start_addr;
                    wrap_flag <= 1'b0;
                end
            end
            if (step) begin
                ptr[cur] <= adv_ptr;
                beats <= beats - lenWidth'(1);
                if (adv_wrap) wrap_flag <= 1'b1;
            end
            inflight <= issue;
            if (pop_f) fifo[0] <= fifo[1];
            if (push) fifo[fidx[0]] <= q;
            fcnt <= fidx + {1'b0, push};
        end
    end
endmodule

// File: doc/glb_instruction_sequencer.md
Name: glb_instruction_sequencer

Overview:
- Parametrised global-buffer engine: executes global_buffer_instruction_t commands against an internal single-port SRAM split into weight, activation and output regions.
- Streams write bursts in and activation read bursts out over valid/ready channels.
- Keeps per-region auto-incrementing pointers with wrap-around.
- Sits between the top-level DMA/controller and the PE-array feeders.

Parameters:
dataSize, 8, bits per element
interfaceDepth, 16, elements per beat; beat width W = dataSize*interfaceDepth
memDepth, 1024, SRAM depth in beats (power of two); addrWidth = clog2(memDepth), localparam
lenWidth, 16, burst-length field width

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  instruction accepted when both high
instr  in  4  global_buffer_instruction_t opcode
instr_len  in  lenWidth  burst length in beats
weight_start_addr / weight_len  in  addrWidth each  weight region
act_start_addr / act_len  in  addrWidth each  activation region
out_start_addr / out_len  in  addrWidth each  output region
wr_data  in  W  write beat
wr_valid  in  1  write beat offered
wr_ready  out  1  write beat accepted when both high
rd_data  out  W  read beat
rd_valid  out  1  read beat offered
rd_ready  in  1  read beat consumed when both high
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on instruction completion
wrap_flag  out  1  sticky: a pointer wrapped
illegal_flag  out  1  sticky: unknown opcode received

Behaviour:
- Reset (nrst low, async): state IDLE; all pointers, latched region starts/lengths, beat counter, FIFO and in-flight counts 0; instr_ready=1, wr_ready=0, rd_valid=0, rd_data=0, busy=0, done=0, wrap_flag=0, illegal_flag=0. Reset mid-burst aborts it; no done pulse.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: instr_ready=1. Opcodes on acceptance:
  - I_NOP: done next cycle.
  - I_POINTER_RESET: latch the three start/len pairs; set wptr=weight_start, aptr=act_start, optr=out_start, rptr=act_start; clear wrap_flag; done next cycle.
  - I_LOAD_WEIGHT / I_LOAD_ACTIVATION / I_LOAD_OUTPUT: select the matching pointer; go to WRITE.
  - I_READ_ACTIVATION: use rptr; go to READ.
  - Other opcode: treated as NOP; set illegal_flag; done next cycle.
- Zero-length bursts: instr_len=0 for load/read completes with done next cycle; no memory access.
- WRITE: wr_ready=1. Each handshake writes mem[ptr]=wr_data, advances ptr, decrements count. At count 0: done pulse, return to IDLE.
- READ: SRAM read latency 1. Accept at edge k; address issued in cycle k+1; first rd_valid no earlier than cycle k+2. Data is buffered in a 2-entry FIFO; reads issue only if FIFO occupancy + in-flight - pop < 2. With rd_ready held high, sustained throughput is 1 beat/cycle. After the last address issues, go to DRAIN; done pulses in the cycle after the final rd handshake.
- Under back-pressure rd_data and rd_valid stay stable.
- Pointer advance: if ptr == start+len-1 (mod memDepth), next ptr = start and wrap_flag sets; else ptr+1 mod memDepth. len=0 means the region spans the full memDepth.
- Pointers persist across instructions; only I_POINTER_RESET or reset reloads them.
- instr_valid outside IDLE is ignored; instr_ready=0 outside IDLE.
- The SRAM is single-port; reads and writes never coincide by construction.
- Lengths and starts are sampled only at POINTER_RESET. Mid-op changes on the config ports have no effect.

Decomposition:
- Shared package: global_buffer_instruction_t, a state enum, and a region struct {start, len} sized by addrWidth.
- Sub-module glb_sram_1rw: parametrised single-port synchronous SRAM (W x memDepth, 1-cycle read). The 2-entry read FIFO stays inline.

Test Plan:
- POINTER_RESET with weight 0/8, act 16/8, out 32/4, then LOAD_WEIGHT len 4 with data 1..4 -> 4 wr handshakes, done once; mem[0..3]=1..4.
- LOAD_ACTIVATION len 8 with data 0xA0..0xA7, then READ_ACTIVATION len 8 with rd_ready=1 -> rd_data 0xA0..0xA7, first rd_valid 2 cycles after accept, then 1 beat/cycle, done after the last beat.
- LOAD_OUTPUT len 6 into region 32/4 -> writes to 32,33,34,35,32,33; wrap_flag=1; a following POINTER_RESET clears it.
- READ_ACTIVATION len 4 with rd_ready toggling 1,0,0,1,... -> no beat lost or duplicated; rd_data stable while stalled.
- Opcode 4'hF -> illegal_flag=1, done pulse, pointers unchanged. instr_len=0 LOAD_WEIGHT -> done next cycle, wr_ready never asserts.
- nrst asserted mid READ after 2 beats -> all outputs at reset values immediately; no done; next POINTER_RESET plus read behaves normally.
